instr_fetch: RTL
================

Name: instr_fetch

Overview:
Fetch stage directly upstream of the decode block. Owns the PC and issues one-outstanding-request fetches over an addr_ok/data_ok instruction bus. Drives the IF/ID instruction/PC register consumed by decode. Handles MIPS branch-delay redirect, exception/ERET flush and decode stall back-pressure.

Parameters:
RESET_PC, 32'hBFC0_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0000, instruction word driven when id_valid_o=0 or on a fetch fault

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  synchronous active-low reset
inst_req_o  out  1  fetch request, held until inst_addr_ok_i
inst_addr_o  out  32  fetch address, stable while inst_req_o=1
inst_addr_ok_i  in  1  request accepted this cycle
inst_data_ok_i  in  1  read data valid this cycle
inst_rdata_i  in  32  read data
id_stall_i  in  1  decode cannot accept; hold IF/ID register
branch_taken_i  in  1  branch/jump in ID resolved taken (one-cycle pulse)
branch_target_i  in  32  target, valid with branch_taken_i
flush_i  in  1  exception/ERET flush (one-cycle pulse)
flush_pc_i  in  32  new PC, valid with flush_i
id_instr_o  out  32  instruction to decode
id_pc_o  out  32  PC of id_instr_o
id_valid_o  out  1  id_instr_o holds a real instruction
id_adel_o  out  1  id_pc_o misaligned (address error on fetch)

Behaviour:
- Reset (resetn=0 at edge): state=IDLE, pc=RESET_PC, inst_req_o=0, id_instr_o=NOP_INSTR, id_pc_o=0, id_valid_o=0, id_adel_o=0, pending_redirect=0, cancel=0, skid buffer empty. Reset mid-transaction abandons everything; inst_data_ok_i is ignored outside WAIT.
- FSM: IDLE -> REQ (unconditionally, the cycle after reset is released).
- REQ: inst_req_o=1, inst_addr_o=pc. On inst_addr_ok_i -> WAIT. If pc[1:0]!=0, no request is issued; the block synthesises NOP_INSTR with id_adel_o=1 as if data had returned this cycle.
- WAIT: inst_req_o=0. On inst_data_ok_i:
  - cancel=1: drop data, clear cancel, -> REQ.
  - otherwise, if id_stall_i=0: load IF/ID (instr, pc, valid=1, adel=0), advance pc, -> REQ (new request visible next cycle). If id_stall_i=1: store into skid buffer, -> HOLD.
- HOLD: inst_req_o=0. When id_stall_i=0: load IF/ID from skid, advance pc, -> REQ.
- id_stall_i=1 holds all IF/ID outputs unchanged.
- pc advance: pc_next = pending_redirect ? redirect_target : pc+4; pending_redirect clears when consumed.
- Branch: branch_taken_i latches pending_redirect=1, redirect_target=branch_target_i. The fetch in flight or next issued (the delay slot, pc = branch_pc+4) completes normally; the fetch after it uses the target. Min taken-branch bubble = bus latency only, delay slot never squashed.
- Flush: flush_i overrides everything, including branch_taken_i in the same cycle. Next edge: id_valid_o=0, id_instr_o=NOP_INSTR, skid emptied, pending_redirect=0, pc=flush_pc_i. In REQ with addr not yet accepted -> stay in REQ, new address next cycle. If inst_addr_ok_i coincides with flush_i, or state=WAIT -> set cancel=1 (stay or go to WAIT). In HOLD -> REQ.
- Flush overrides id_stall_i.
- Output id_valid_o=0 whenever IF/ID was not loaded while unstalled (bubble): id_instr_o=NOP_INSTR.
- pc arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds output ports perf_fetch_cnt_o[31:0] and perf_bubble_cnt_o[31:0].
- perf_fetch_cnt_o: increments for each instruction loaded into IF/ID with id_valid_o=1.
- perf_bubble_cnt_o: increments each cycle id_stall_i=0 and id_valid_o=0.
- Both reset to 0 and wrap at 2^32.
When not defined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset release, 1-cycle addr_ok and data_ok -> first request at 32'hBFC0_0000; id_pc_o sequence BFC00000, BFC00004, BFC00008 with id_valid_o=1.
- data_ok arrives while id_stall_i=1 for 3 cycles -> outputs unchanged during stall; the skidded instruction appears the cycle after stall drops; no extra request is issued while in HOLD.
- Branch at BFC00010 asserts branch_taken_i, target=BFC00100 -> delay slot BFC00014 is delivered, then BFC00100; BFC00018 is never requested.
- flush_i (flush_pc_i=BFC00380) while in WAIT -> the returning data_ok is dropped, id_valid_o=0 next cycle, next request addr=BFC00380.
- flush_i and branch_taken_i in the same cycle -> flush wins; the branch target is never fetched.
- branch_target_i=BFC00102 -> no bus request; id_instr_o=0, id_adel_o=1, id_pc_o=BFC00102.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage owning the PC, one outstanding addr_ok/data_ok
// request, IF/ID register with one-entry skid, branch-delay redirect, flush.
// Ports: clk/resetn (sync active-low); inst_* bus master; id_stall_i,
// branch_taken_i/branch_target_i, flush_i/flush_pc_i from later stages;
// id_instr_o/id_pc_o/id_valid_o/id_adel_o to decode.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt_o/perf_bubble_cnt_o.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_addr_ok_i,
   input  logic        inst_data_ok_i,
   input  logic [31:0] inst_rdata_i,
   input  logic        id_stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   output logic        id_valid_o,
   output logic        id_adel_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt_o,
   output logic [31:0] perf_bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] redirect_target;
   logic        pending_redirect;
   logic        cancel;
   logic [31:0] skid_instr;
   logic        skid_adel;

   logic        misaligned;
   logic        fault_hit;
   logic        data_hit;
   logic        skid_go;
   logic        deliver;
   logic [31:0] fresh_instr;
   logic [31:0] deliver_instr;
   logic        deliver_adel;
   logic [31:0] pc_adv;

   assign misaligned  = (pc[1:0] != 2'b00);
   assign inst_req_o  = (state == REQ) && !misaligned;
   assign inst_addr_o = pc;

   // A misaligned PC never reaches the bus; it completes as a faulting NOP.
   assign fault_hit   = (state == REQ) && misaligned;
   assign data_hit    = (state == WAIT) && inst_data_ok_i && !cancel;
   assign skid_go     = (state == HOLD) && !id_stall_i;
   assign deliver     = !flush_i && !id_stall_i
                        && (fault_hit || data_hit || skid_go);

   assign fresh_instr   = fault_hit ? NOP_INSTR : inst_rdata_i;
   assign deliver_instr = (state == HOLD) ? skid_instr : fresh_instr;
   assign deliver_adel  = (state == HOLD) ? skid_adel : fault_hit;

   // A branch resolving in the same cycle the delay slot is delivered
   // steers the very next fetch straight to its target.
   always_comb begin
      pc_adv = pc + 32'd4;
      if (branch_taken_i)
         pc_adv = branch_target_i;
      else if (pending_redirect)
         pc_adv = redirect_target;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state            <= IDLE;
         pc               <= RESET_PC;
         redirect_target  <= 32'h0;
         pending_redirect <= 1'b0;
         cancel           <= 1'b0;
         skid_instr       <= NOP_INSTR;
         skid_adel        <= 1'b0;
         id_instr_o       <= NOP_INSTR;
         id_pc_o          <= 32'h0;
         id_valid_o       <= 1'b0;
         id_adel_o        <= 1'b0;
      end else if (flush_i) begin
         pc               <= flush_pc_i;
         pending_redirect <= 1'b0;
         id_instr_o       <= NOP_INSTR;
         id_valid_o       <= 1'b0;
         id_adel_o        <= 1'b0;
         unique case (state)
            IDLE, HOLD: state <= REQ;
            REQ: begin
               if (inst_req_o && inst_addr_ok_i) begin
                  cancel <= 1'b1;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               // Data returning with the flush is simply dropped here.
               if (inst_data_ok_i) begin
                  cancel <= 1'b0;
                  state  <= REQ;
               end else begin
                  cancel <= 1'b1;
               end
            end
         endcase
      end else begin
         if (branch_taken_i) begin
            pending_redirect <= 1'b1;
            redirect_target  <= branch_target_i;
         end

         if (!id_stall_i) begin
            if (deliver) begin
               id_instr_o <= deliver_instr;
               id_pc_o    <= pc;
               id_valid_o <= 1'b1;
               id_adel_o  <= deliver_adel;
            end else begin
               id_instr_o <= NOP_INSTR;
               id_valid_o <= 1'b0;
               id_adel_o  <= 1'b0;
            end
         end

         unique case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (misaligned) begin
                  if (!id_stall_i) begin
                     pc               <= pc_adv;
                     pending_redirect <= 1'b0;
                  end else begin
                     skid_instr <= NOP_INSTR;
                     skid_adel  <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (inst_addr_ok_i) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (inst_data_ok_i) begin
                  if (cancel) begin
                     cancel <= 1'b0;
                     state  <= REQ;
                  end else if (!id_stall_i) begin
                     pc               <= pc_adv;
                     pending_redirect <= 1'b0;
                     state            <= REQ;
                  end else begin
                     skid_instr <= inst_rdata_i;
                     skid_adel  <= 1'b0;
                     state      <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!id_stall_i) begin
                  pc               <= pc_adv;
                  pending_redirect <= 1'b0;
                  state            <= REQ;
               end
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_fetch_cnt_o  <= 32'h0;
         perf_bubble_cnt_o <= 32'h0;
      end else begin
         if (deliver)
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
         if (!id_stall_i && !id_valid_o)
            perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule
